// File: rtl/taiga_fwft_fifo_if.sv
// Push/pop handshake and status bundle between a producer/consumer and taiga_fwft_fifo.
interface taiga_fwft_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  empty;
  logic                  almost_empty;
  logic                  full;
  logic                  almost_full;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, data_in, pop,
    input  data_out, valid, empty, almost_empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid, empty, almost_empty, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/taiga_fwft_fifo.sv
// First-word-fall-through FIFO with count-decoded status flags and sticky overflow/underflow.
module taiga_fwft_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  taiga_fwft_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic pop_ok;
  logic push_ok;
  logic is_full;

  assign is_full = (cnt_q == CNT_W'(DEPTH));
  assign pop_ok  = bus.pop & (cnt_q != '0);
  // When full, a push is only taken if the simultaneous pop frees the slot at wr_ptr == rd_ptr.
  assign push_ok = bus.push & (~is_full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  // Power-of-two depth: pointer increment wraps naturally at DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop_ok)  rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push_ok && !pop_ok) begin
      cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
    end else if (pop_ok && !push_ok) begin
      cnt_q <= CNT_W'(cnt_q - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && !push_ok) overflow_q  <= 1'b1;
      if (bus.pop  && !pop_ok)  underflow_q <= 1'b1;
    end
  end

  // Outputs depend on registered state only; no path from push/pop.
  assign bus.data_out     = mem_q[rd_ptr_q];
  assign bus.empty        = (cnt_q == '0);
  assign bus.valid        = (cnt_q != '0);
  assign bus.almost_empty = (cnt_q == CNT_W'(1));
  assign bus.full         = is_full;
  assign bus.almost_full  = (cnt_q == CNT_W'(DEPTH - 1));
  assign bus.count        = cnt_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_taiga_fwft_fifo.sv
// Scoreboard bench for taiga_fwft_fifo: fill/drain, wrap, full push+pop, overflow, underflow, async reset.
module tb_taiga_fwft_fifo;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [DW-1:0] sb[$];
  logic          m_ovf;
  logic          m_unf;

  taiga_fwft_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  taiga_fwft_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_status();
    int n;
    n = sb.size();
    chk("count",        64'(bus.count),        64'(n));
    chk("empty",        64'(bus.empty),        64'(n == 0));
    chk("valid",        64'(bus.valid),        64'(n != 0));
    chk("almost_empty", 64'(bus.almost_empty), 64'(n == 1));
    chk("almost_full",  64'(bus.almost_full),  64'(n == DEPTH - 1));
    chk("full",         64'(bus.full),         64'(n == DEPTH));
    chk("overflow",     64'(bus.overflow),     64'(m_ovf));
    chk("underflow",    64'(bus.underflow),    64'(m_unf));
    if (n != 0) chk("head", 64'(bus.data_out), 64'(sb[0]));
  endtask

  // One clock of stimulus: compare popped data before the edge, status after it.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q);
    logic          pop_ok;
    logic          push_ok;
    logic [DW-1:0] exp;
    @(negedge clk);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = q;
    pop_ok  = q && (sb.size() != 0);
    push_ok = p && ((sb.size() < DEPTH) || pop_ok);
    if (pop_ok) begin
      exp = sb.pop_front();
      chk("pop_data", 64'(bus.data_out), 64'(exp));
    end
    if (q && !pop_ok) m_unf = 1'b1;
    if (p && !push_ok) m_ovf = 1'b1;
    if (push_ok) sb.push_back(d);
    @(posedge clk);
    #1;
    chk_status();
  endtask

  task automatic drain();
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
  endtask

  task automatic chk_reset_state();
    chk("rst_count",     64'(bus.count),        64'd0);
    chk("rst_empty",     64'(bus.empty),        64'd1);
    chk("rst_valid",     64'(bus.valid),        64'd0);
    chk("rst_aempty",    64'(bus.almost_empty), 64'd0);
    chk("rst_afull",     64'(bus.almost_full),  64'd0);
    chk("rst_full",      64'(bus.full),         64'd0);
    chk("rst_data_out",  64'(bus.data_out),     64'd0);
    chk("rst_overflow",  64'(bus.overflow),     64'd0);
    chk("rst_underflow", 64'(bus.underflow),    64'd0);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
    rst_n       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill then drain
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b1, 32'h33, 1'b0);
    cyc(1'b1, 32'h44, 1'b0);
    drain();

    // Wrap-around with two entries resident
    cyc(1'b1, 32'h100, 1'b0);
    cyc(1'b1, 32'h101, 1'b0);
    for (int i = 2; i < 10; i++) cyc(1'b1, DW'(32'h100 + i), 1'b1);
    drain();

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(32'hA0 + i), 1'b0);
    cyc(1'b1, 32'hA4, 1'b1);
    chk("full_sim_head", 64'(bus.data_out), 64'hA1);
    drain();

    // Overflow: push into a full FIFO without pop is dropped
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(32'hB0 + i), 1'b0);
    cyc(1'b1, 32'hFF, 1'b0);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    drain();

    // Underflow: pop on empty with push, then a lone pop
    cyc(1'b1, 32'h5A, 1'b1);
    chk("unf_data", 64'(bus.data_out), 64'h5A);
    chk("unf_set",  64'(bus.underflow), 64'd1);
    drain();
    cyc(1'b0, '0, 1'b1);

    // Asynchronous reset mid-cycle with push held high
    cyc(1'b1, 32'hC0, 1'b0);
    cyc(1'b1, 32'hC1, 1'b0);
    cyc(1'b1, 32'hC2, 1'b0);
    @(posedge clk);
    #3;
    bus.push    = 1'b1;
    bus.data_in = 32'hDEAD;
    rst_n       = 1'b0;
    #1;
    chk_reset_state();
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold_count", 64'(bus.count), 64'd0);
    @(negedge clk);
    bus.push = 1'b0;
    rst_n    = 1'b1;
    cyc(1'b1, 32'h77, 1'b0);
    chk("post_rst_data", 64'(bus.data_out), 64'h77);
    drain();
    cyc(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
